// File: rtl/echo_pkg.sv
// Shared types and helpers for the multi-tap echo processor.
//   state_t    : sample-processing FSM states
//   GAIN_MUTE  : attenuation code that silences a tap
//   to_signed  : offset-binary -> two's complement (flip the sample MSB)
//   to_offset  : two's complement -> offset-binary (same MSB flip)
//   saturate   : clamp a signed value into a w-bit signed range
package echo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      SAT,
      WR
   } state_t;

   localparam logic [2:0] GAIN_MUTE = 3'd7;

   // Offset binary and two's complement differ only in the MSB of the
   // w-bit word, so both conversions are the same bit flip.
   function automatic logic [31:0] to_signed(input logic [31:0] v, input int w);
      return v ^ (32'd1 << (w - 1));
   endfunction

   function automatic logic [31:0] to_offset(input logic [31:0] v, input int w);
      return v ^ (32'd1 << (w - 1));
   endfunction

   function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Echo delay line storage: simple dual-port RAM, DW bits x 2^AW words.
//   clk     : clock
//   we      : write enable (synchronous write)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, data appears on rd_data one cycle later
//   rd_data : registered read data
// Contents are deliberately not reset so the array maps onto block RAM.
module delay_ram #(
   parameter int DW = 10,
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/echo_multitap.sv
// Multi-tap echo processor for the ADC -> DAC audio chain.
//   sysclk     : system clock
//   reset      : asynchronous, active-high
//   data_valid : one-cycle strobe, new sample on data_in
//   data_in    : ADC sample, offset binary
//   delay      : per-tap delay in samples, tap k = [k*AW +: AW]
//   gain_shift : per-tap attenuation code, tap k = [k*3 +: 3], 7 = muted
//   mode       : 0 = feed-forward (store input), 1 = feedback (store output)
//   bypass     : 1 = data_out follows data_in (buffer is still written)
//   data_out   : processed sample, offset binary
//   out_valid  : one-cycle pulse when data_out updates
//   busy       : high while a sample is being processed
//   overrun    : sticky, a sample arrived while busy and was dropped
module echo_multitap
   import echo_pkg::*;
#(
   parameter int DW    = 10,
   parameter int AW    = 13,
   parameter int NTAPS = 2
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic                  data_valid,
   input  logic [DW-1:0]         data_in,
   input  logic [NTAPS*AW-1:0]   delay,
   input  logic [NTAPS*3-1:0]    gain_shift,
   input  logic                  mode,
   input  logic                  bypass,
   output logic [DW-1:0]         data_out,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int AccW = DW + 3;
   localparam logic [2:0] LAST_RD = 3'(NTAPS);
   localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

   state_t                     state_q, state_d;
   logic [2:0]                 cnt_q, cnt_d;
   logic signed [AccW-1:0]     acc_q, acc_d;
   logic signed [DW-1:0]       x_q, x_d;
   logic signed [DW-1:0]       y_q, y_d;
   logic [DW-1:0]              din_q, din_d;
   logic [NTAPS*AW-1:0]        delay_q, delay_d;
   logic [NTAPS*3-1:0]         gain_q, gain_d;
   logic                       mode_q, mode_d;
   logic                       bypass_q, bypass_d;
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]              fill_q, fill_d;
   logic [DW-1:0]              data_out_q, data_out_d;
   logic                       out_valid_q, out_valid_d;
   logic                       overrun_q, overrun_d;

   logic                       ram_we;
   logic [AW-1:0]              rd_addr;
   logic [DW-1:0]              rd_data;
   logic [DW-1:0]              ram_wdata;

   logic [AW-1:0]              rd_delay;
   logic [AW-1:0]              tap_delay;
   logic [2:0]                 tap_gain;
   logic signed [AccW-1:0]     tap_ext;
   logic signed [AccW-1:0]     tap_term;
   logic signed [DW-1:0]       x_new;
   logic signed [DW-1:0]       y_new;

   delay_ram #(
      .DW(DW),
      .AW(AW)
   ) u_ram (
      .clk     (sysclk),
      .we      (ram_we),
      .wr_addr (wr_ptr_q),
      .wr_data (ram_wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Tap scaling. The RAM answers one cycle after the address is issued,
   // so in RD cycle i the address belongs to tap i while the data on
   // rd_data belongs to tap i-1. A tap is silent when muted, when its
   // delay is zero, or when it reaches further back than anything written
   // since reset (stale RAM contents must not leak out).
   always_comb begin
      rd_delay  = '0;
      tap_delay = '0;
      tap_gain  = GAIN_MUTE;
      for (int k = 0; k < NTAPS; k++) begin
         if (3'(k) == cnt_q) begin
            rd_delay = delay_q[k*AW +: AW];
         end
         if (3'(k + 1) == cnt_q) begin
            tap_delay = delay_q[k*AW +: AW];
            tap_gain  = gain_q[k*3 +: 3];
         end
      end
      tap_ext = {{3{rd_data[DW-1]}}, rd_data};
      if (tap_gain == GAIN_MUTE || tap_delay == '0 || tap_delay > fill_q) begin
         tap_term = '0;
      end else begin
         tap_term = tap_ext >>> (tap_gain + 3'd1);
      end
   end

   // Sample FSM: IDLE latches a sample and all controls, RD walks the taps
   // into the accumulator, SAT clamps and presents the output, WR commits
   // the sample to the delay line. out_valid is registered in SAT so it is
   // high during the WR cycle, NTAPS+3 cycles after the strobe.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      x_d         = x_q;
      y_d         = y_q;
      din_d       = din_q;
      delay_d     = delay_q;
      gain_d      = gain_q;
      mode_d      = mode_q;
      bypass_d    = bypass_q;
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      ram_we      = 1'b0;
      rd_addr     = wr_ptr_q;
      ram_wdata   = mode_q ? y_q : x_q;
      x_new       = DW'(to_signed(32'(data_in), DW));
      y_new       = DW'(saturate(32'(acc_q), DW));

      case (state_q)
         IDLE: begin
            if (data_valid) begin
               din_d    = data_in;
               x_d      = x_new;
               acc_d    = {{3{x_new[DW-1]}}, x_new};
               delay_d  = delay;
               gain_d   = gain_shift;
               mode_d   = mode;
               bypass_d = bypass;
               cnt_d    = '0;
               state_d  = RD;
            end
         end
         RD: begin
            if (cnt_q != LAST_RD) begin
               rd_addr = wr_ptr_q - rd_delay;
            end
            if (cnt_q != '0) begin
               acc_d = acc_q + tap_term;
            end
            if (cnt_q == LAST_RD) begin
               state_d = SAT;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         SAT: begin
            y_d         = y_new;
            data_out_d  = bypass_q ? din_q : DW'(to_offset(32'(y_new), DW));
            out_valid_d = 1'b1;
            state_d     = WR;
         end
         WR: begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != '1) begin
               fill_d = fill_q + AW'(1);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (data_valid && state_q != IDLE) begin
         overrun_d = 1'b1;
      end
   end

   // State and datapath registers; reset aborts any sample in flight.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         din_q       <= '0;
         delay_q     <= '0;
         gain_q      <= '0;
         mode_q      <= 1'b0;
         bypass_q    <= 1'b0;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         data_out_q  <= MIDSCALE;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         y_q         <= y_d;
         din_q       <= din_d;
         delay_q     <= delay_d;
         gain_q      <= gain_d;
         mode_q      <= mode_d;
         bypass_q    <= bypass_d;
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_multitap.sv
// Directed bench for echo_multitap (DW=10, AW=4, NTAPS=2, midscale 512).
module tb_echo_multitap;

   localparam int DW    = 10;
   localparam int AW    = 4;
   localparam int NTAPS = 2;

   logic                sysclk = 1'b0;
   logic                reset;
   logic                data_valid;
   logic [DW-1:0]       data_in;
   logic [NTAPS*AW-1:0] delay;
   logic [NTAPS*3-1:0]  gain_shift;
   logic                mode;
   logic                bypass;
   logic [DW-1:0]       data_out;
   logic                out_valid;
   logic                busy;
   logic                overrun;

   int total = 0;
   int bad   = 0;

   always #5 sysclk = ~sysclk;

   echo_multitap #(
      .DW(DW),
      .AW(AW),
      .NTAPS(NTAPS)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .data_valid (data_valid),
      .data_in    (data_in),
      .delay      (delay),
      .gain_shift (gain_shift),
      .mode       (mode),
      .bypass     (bypass),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Called at a negedge: strobe one sample, wait (bounded) for out_valid,
   // return the output and the strobe-to-out_valid latency in cycles.
   task automatic applyStimulus(input logic [DW-1:0] din,
                                output logic [DW-1:0] dout, output int lat);
      data_in    = din;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge sysclk);
         lat++;
      end
      if (out_valid !== 1'b1) begin
         checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
      end
      dout = data_out;
      @(negedge sysclk);
   endtask

   task automatic runExpect(input string tag, input logic [DW-1:0] din,
                            input int expd);
      logic [DW-1:0] dout;
      int lat;
      applyStimulus(din, dout, lat);
      checkOutput(tag, 32'(dout), 32'(expd));
      checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      @(negedge sysclk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fb_in  [7];
      int fb_exp [7];
      int pulses;

      data_valid = 1'b0;
      data_in    = 10'd512;
      delay      = '0;
      gain_shift = 6'o77;
      mode       = 1'b0;
      bypass     = 1'b0;
      reset      = 1'b1;
      repeat (3) @(negedge sysclk);
      checkOutput("rst_data_out", 32'(data_out), 32'd512);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      @(negedge sysclk);

      // Feed-forward impulse, tap0 delay 3 at half gain, tap1 muted.
      delay      = {4'd1, 4'd3};
      gain_shift = {3'd7, 3'd0};
      runExpect("ff_n0", 10'd612, 612);
      runExpect("ff_n1", 10'd512, 512);
      runExpect("ff_n2", 10'd512, 512);
      runExpect("ff_n3", 10'd512, 562);
      runExpect("ff_n4", 10'd512, 512);
      checkOutput("ff_no_overrun", 32'(overrun), 32'd0);

      // Feedback comb, tap0 delay 2: impulse decays by half every 2 samples.
      doReset();
      mode   = 1'b1;
      delay  = {4'd1, 4'd2};
      fb_in  = '{612, 512, 512, 512, 512, 512, 512};
      fb_exp = '{612, 512, 562, 512, 537, 512, 524};
      for (int i = 0; i < 7; i++) begin
         runExpect($sformatf("fb_n%0d", i), 10'(fb_in[i]), fb_exp[i]);
      end

      // Saturation at both rails with tap0 delay 1.
      doReset();
      mode  = 1'b0;
      delay = {4'd1, 4'd1};
      runExpect("sat_hi_n0", 10'd1023, 1023);
      runExpect("sat_hi_n1", 10'd1023, 1023);
      runExpect("sat_mix_n2", 10'd0, 255);
      runExpect("sat_lo_n3", 10'd0, 0);

      // Fill RAM with 900 through fully muted taps, then abort a sample.
      doReset();
      gain_shift = {3'd7, 3'd7};
      for (int i = 0; i < 15; i++) begin
         runExpect($sformatf("mute_n%0d", i), 10'd900, 900);
      end
      data_in    = 10'd900;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      @(negedge sysclk);
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_data_out", 32'(data_out), 32'd512);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      @(negedge sysclk);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge sysclk);
         if (out_valid === 1'b1) pulses++;
      end
      checkOutput("abort_no_pulse", 32'(pulses), 32'd0);

      // Fill gating: stale 900s must not reach the output after reset.
      delay      = {4'd1, 4'd5};
      gain_shift = {3'd7, 3'd0};
      for (int i = 0; i < 7; i++) begin
         runExpect($sformatf("fill_n%0d", i), 10'd512, 512);
      end

      // Overrun: second strobe lands while busy and is dropped.
      doReset();
      data_in    = 10'd600;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      @(negedge sysclk);
      data_in    = 10'd700;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      pulses     = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid === 1'b1) pulses++;
         @(negedge sysclk);
      end
      checkOutput("ovr_pulses", 32'(pulses), 32'd1);
      checkOutput("ovr_data_out", 32'(data_out), 32'd600);
      checkOutput("ovr_flag", 32'(overrun), 32'd1);
      repeat (20) @(negedge sysclk);
      checkOutput("ovr_sticky", 32'(overrun), 32'd1);
      doReset();
      checkOutput("ovr_cleared", 32'(overrun), 32'd0);

      // Bypass with echo configured; buffer still fills underneath.
      delay      = {4'd1, 4'd1};
      gain_shift = {3'd7, 3'd0};
      bypass     = 1'b1;
      runExpect("byp_n0", 10'd700, 700);
      runExpect("byp_n1", 10'd300, 300);
      runExpect("byp_n2", 10'd1000, 1000);
      bypass = 1'b0;
      runExpect("byp_release", 10'd512, 756);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
